// File: rtl/memory_cycle.sv
// Memory stage with a variable-latency data-memory handshake and the M->W pipeline register.
// The stage stalls upstream until the memory acknowledges, and aborts the access after TIMEOUT wait cycles.
module memory_cycle #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [17:0] PCPlus4M,
    input  logic [17:0] WriteDataM,
    input  logic [17:0] ALU_ResultM,
    input  logic [1:0]  RGB_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [17:0] dmem_addr,
    output logic [17:0] dmem_wdata,
    input  logic [17:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [1:0]  RGB_W,
    output logic [17:0] PCPlus4W,
    output logic [17:0] ALU_ResultW,
    output logic [17:0] ReadDataW,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    state_t      state, state_nx;
    logic [4:0]  count, count_nx;
    logic        mem_op;
    logic        timeout_hit;
    logic        load_w, abort_w, bubble_w;

    assign mem_op      = MemWriteM | ResultSrcM;
    assign timeout_hit = (state == WAIT) && (count == TIMEOUT_CNT);

    // Reset gating keeps the memory and hazard unit quiet while the stage is being cleared.
    assign dmem_req   = mem_op & ~rst;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALU_ResultM;
    assign dmem_wdata = WriteDataM;
    assign StallM     = mem_op & ~dmem_ack & ~timeout_hit & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 5'd0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // An acknowledge outranks a simultaneous timeout, so a late-but-valid response still completes.
    always_comb begin
        state_nx = state;
        count_nx = count;
        load_w   = 1'b0;
        abort_w  = 1'b0;
        bubble_w = 1'b0;
        if (!mem_op || dmem_ack) begin
            load_w   = 1'b1;
            state_nx = IDLE;
            count_nx = 5'd0;
        end else if (timeout_hit) begin
            abort_w  = 1'b1;
            state_nx = IDLE;
            count_nx = 5'd0;
        end else begin
            bubble_w = 1'b1;
            state_nx = WAIT;
            count_nx = count + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            RGB_W       <= 2'd0;
            PCPlus4W    <= 18'd0;
            ALU_ResultW <= 18'd0;
            ReadDataW   <= 18'd0;
            mem_err     <= 1'b0;
        end else if (load_w || abort_w) begin
            RegWriteW   <= RegWriteM & ~abort_w;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            RGB_W       <= RGB_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            if (abort_w) begin
                ReadDataW <= 18'd0;
                mem_err   <= 1'b1;
            end else if (mem_op && ResultSrcM) begin
                ReadDataW <= dmem_rdata;
            end
        end else if (bubble_w) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: a transaction-level model predicts each retired instruction
// and how many stall cycles precede it; a monitor compares what the stage presents.
module tb_memory_cycle;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [17:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic [1:0]  RGB_M;
    logic        dmem_req, dmem_we;
    logic [17:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        StallM;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [1:0]  RGB_W;
    logic [17:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        mem_err;

    memory_cycle #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .RGB_M(RGB_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .RGB_W(RGB_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, rs, err, mem, we;
        logic [4:0]  rd;
        logic [1:0]  rgb;
        logic [17:0] pc, alu, rdata, addr, wdata;
        int          stalls;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [17:0] m_rdw = 18'd0;
    logic        m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_nop();
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0;
        RD_M = 5'd0; PCPlus4M = 18'd0; WriteDataM = 18'd0; ALU_ResultM = 18'd0; RGB_M = 2'd0;
        dmem_ack = 1'b0; dmem_rdata = 18'd0;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. lat = cycles before the ack (beyond TIMEOUT = never).
    task automatic issue(input int kind, input logic rw, input logic [4:0] rd, input logic [1:0] rgb,
                         input logic [17:0] pc, input logic [17:0] wd, input logic [17:0] alu,
                         input int lat, input logic [17:0] ack_data);
        exp_t e;
        logic mem, ld, adv;
        int   c;
        mem = (kind != 0);
        ld  = (kind == 1);
        e.mem = mem; e.we = (kind == 2); e.addr = alu; e.wdata = wd;
        e.rd = rd; e.rgb = rgb; e.pc = pc; e.alu = alu; e.rs = ld;
        if (!mem) begin
            e.stalls = 0; e.rw = rw;
        end else if (lat <= TIMEOUT) begin
            e.stalls = lat; e.rw = rw;
            if (ld) m_rdw = ack_data;
        end else begin
            e.stalls = TIMEOUT; e.rw = 1'b0; m_rdw = 18'd0; m_err = 1'b1;
        end
        e.rdata = m_rdw;
        e.err   = m_err;
        q.push_back(e);

        RegWriteM = rw; MemWriteM = (kind == 2); ResultSrcM = ld;
        RD_M = rd; RGB_M = rgb; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
        c = 0;
        forever begin
            if (mem) begin
                dmem_ack   = (c == lat);
                dmem_rdata = (c == lat) ? ack_data : 18'($urandom);
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = 18'($urandom);
            end
            @(negedge clk);
            adv = !StallM;
            @(posedge clk);
            #2;
            if (adv) break;
            c++;
            if (c > TIMEOUT + 4) begin
                checks++; errors++;
                $display("FAIL stall_bound actual=%0d required<=%0d", c, TIMEOUT);
                break;
            end
        end
    endtask

    // Monitor: a cycle with StallM high must put a bubble in W; otherwise the head instruction retires.
    initial begin
        logic st, rq, we;
        logic [17:0] ad, wdv;
        int scnt;
        exp_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            st = StallM; rq = dmem_req; ad = dmem_addr; we = dmem_we; wdv = dmem_wdata;
            if (mon_en && q.size() > 0) begin
                chk("dmem_req", 32'(rq), 32'(q[0].mem));
                if (q[0].mem) begin
                    chk("dmem_addr", 32'(ad), 32'(q[0].addr));
                    chk("dmem_we", 32'(we), 32'(q[0].we));
                    chk("dmem_wdata", 32'(wdv), 32'(q[0].wdata));
                end
            end
            @(posedge clk);
            #1;
            if (!mon_en) begin
                scnt = 0;
            end else if (st) begin
                scnt++;
                chk("bubble_regwrite", 32'(RegWriteW), 32'd0);
                chk("bubble_resultsrc", 32'(ResultSrcW), 32'd0);
            end else if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_retire actual=1 required=0");
            end else begin
                e = q.pop_front();
                chk("stall_cycles", 32'(scnt), 32'(e.stalls));
                chk("RegWriteW", 32'(RegWriteW), 32'(e.rw));
                chk("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
                chk("RD_W", 32'(RD_W), 32'(e.rd));
                chk("RGB_W", 32'(RGB_W), 32'(e.rgb));
                chk("PCPlus4W", 32'(PCPlus4W), 32'(e.pc));
                chk("ALU_ResultW", 32'(ALU_ResultW), 32'(e.alu));
                chk("ReadDataW", 32'(ReadDataW), 32'(e.rdata));
                chk("mem_err", 32'(mem_err), 32'(e.err));
                scnt = 0;
            end
        end
    end

    task automatic chk_w_zero(input string tag);
        chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_StallM"}, 32'(StallM), 32'd0);
        chk({tag, "_RegWriteW"}, 32'(RegWriteW), 32'd0);
        chk({tag, "_ResultSrcW"}, 32'(ResultSrcW), 32'd0);
        chk({tag, "_RD_W"}, 32'(RD_W), 32'd0);
        chk({tag, "_RGB_W"}, 32'(RGB_W), 32'd0);
        chk({tag, "_PCPlus4W"}, 32'(PCPlus4W), 32'd0);
        chk({tag, "_ALU_ResultW"}, 32'(ALU_ResultW), 32'd0);
        chk({tag, "_ReadDataW"}, 32'(ReadDataW), 32'd0);
        chk({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        int kind, lat;
        logic rw;
        set_nop();
        rst = 1'b1;
        ResultSrcM = 1'b1;
        #1;
        chk_w_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        chk_w_zero("reset_hold");
        set_nop();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        mon_en = 1'b1;

        issue(0, 1'b1, 5'd5, 2'd1, 18'h00004, 18'h00000, 18'h00123, 0, 18'h0);
        issue(1, 1'b1, 5'd3, 2'd2, 18'h00008, 18'h00000, 18'h00040, 0, 18'h2AAAA);
        issue(2, 1'b0, 5'd0, 2'd0, 18'h0000C, 18'h00777, 18'h00010, 3, 18'h0);
        issue(0, 1'b1, 5'd7, 2'd3, 18'h00010, 18'h00001, 18'h00055, 0, 18'h0);
        issue(1, 1'b1, 5'd9, 2'd1, 18'h00014, 18'h00000, 18'h00100, TIMEOUT, 18'h15555);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0)      lat = $urandom_range(TIMEOUT + 1, TIMEOUT + 3);
            else if ($urandom_range(0, 1) == 0) lat = $urandom_range(0, TIMEOUT);
            else                                lat = $urandom_range(0, 3);
            rw = (kind == 2) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            issue(kind, rw, 5'($urandom), 2'($urandom), 18'($urandom), 18'($urandom),
                  18'($urandom), lat, 18'($urandom));
        end

        issue(1, 1'b1, 5'd12, 2'd2, 18'h00020, 18'h00000, 18'h00200, 100, 18'h3FFFF);
        issue(0, 1'b1, 5'd13, 2'd0, 18'h00024, 18'h00000, 18'h00300, 0, 18'h0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        // Abandon a load part-way through its wait with a reset pulse.
        mon_en = 1'b0;
        RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0; ALU_ResultM = 18'h00400;
        RD_M = 5'd4; dmem_ack = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_w_zero("midwait_reset");
        set_nop();
        @(negedge clk);
        rst = 1'b0;
        m_rdw = 18'd0;
        m_err = 1'b0;
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        issue(1, 1'b1, 5'd6, 2'd1, 18'h00030, 18'h00000, 18'h00044, 2, 18'h01234);
        issue(0, 1'b0, 5'd1, 2'd0, 18'h00034, 18'h00000, 18'h00001, 0, 18'h0);
        chk("queue_drained_end", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
